tlc_sensor_cond: RTL and testbench

Traffic-sensor conditioner that sits directly upstream of the 2-street traffic light controller and produces its Ta/Tb inputs. Raw loop-detector lines (arrival and departure per street) are asynchronous and noisy. Each line is synchronised and debounced, and its rising edges are turned into single-cycle events. The events drive a per-street queued-car counter. Ta/Tb assert whenever that street's queue is non-empty.

---
 rtl/light_package.sv | 26 ++
 rtl/tlc_sensor_cond_debounce.sv | 51 +++++
 rtl/tlc_sensor_cond.sv | 97 +++++++++
 tb/tb_tlc_sensor_cond.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/light_package.sv
// Shared constants and types for the traffic light controller and its sensor conditioner.
package light_package;

   localparam int unsigned DEBOUNCE_DEFAULT = 3;
   localparam int unsigned CNT_W_DEFAULT    = 4;
   localparam int unsigned NUM_STREETS      = 2;

   typedef enum logic [1:0] {
      CntHold,
      CntInc,
      CntDec
   } cnt_op_e;

   // Simultaneous arrival and departure cancel out.
   function automatic cnt_op_e cnt_op(input logic arr_ev, input logic dep_ev);
      cnt_op_e op;
      op = CntHold;
      if (arr_ev && !dep_ev) begin
         op = CntInc;
      end else if (dep_ev && !arr_ev) begin
         op = CntDec;
      end
      return op;
   endfunction

endpackage

// File: rtl/tlc_sensor_cond_debounce.sv
// Two-flop synchroniser, debouncer and rising-edge event for one raw detector line.
module sensor_debounce
   import light_package::*;
#(
   parameter int unsigned DEBOUNCE = DEBOUNCE_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic ev
);

   localparam int unsigned DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

   logic          s1_q, s2_q;
   logic          deb_q, deb_d;
   logic          deb_dly_q;
   logic [DW-1:0] dcnt_q, dcnt_d;

   // Any sample matching the current level restarts qualification.
   always_comb begin
      deb_d  = deb_q;
      dcnt_d = '0;
      if (s2_q != deb_q) begin
         if (dcnt_q == DW'(DEBOUNCE - 1)) begin
            deb_d = s2_q;
         end else begin
            dcnt_d = dcnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q      <= 1'b0;
         s2_q      <= 1'b0;
         deb_q     <= 1'b0;
         deb_dly_q <= 1'b0;
         dcnt_q    <= '0;
      end else begin
         s1_q      <= raw;
         s2_q      <= s1_q;
         deb_q     <= deb_d;
         deb_dly_q <= deb_q;
         dcnt_q    <= dcnt_d;
      end
   end

   assign ev = deb_q & ~deb_dly_q;

endmodule

// File: rtl/tlc_sensor_cond.sv
// Conditions raw loop-detector lines into per-street queued-car counts and Ta/Tb presence.
module tlc_sensor_cond
   import light_package::*;
#(
   parameter int unsigned DEBOUNCE = DEBOUNCE_DEFAULT,
   parameter int unsigned CNT_W    = CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             arr_a,
   input  logic             dep_a,
   input  logic             arr_b,
   input  logic             dep_b,
   output logic             Ta,
   output logic             Tb,
   output logic [CNT_W-1:0] cnt_a,
   output logic [CNT_W-1:0] cnt_b,
   output logic             ovf_a,
   output logic             ovf_b,
   output logic             unf_a,
   output logic             unf_b
);

   localparam logic [CNT_W-1:0] CntMax = '1;

   logic [NUM_STREETS-1:0]            arr_raw, dep_raw;
   logic [NUM_STREETS-1:0]            arr_ev, dep_ev;
   logic [NUM_STREETS-1:0][CNT_W-1:0] cnt_all;
   logic [NUM_STREETS-1:0]            ovf_all, unf_all;

   assign arr_raw = {arr_b, arr_a};
   assign dep_raw = {dep_b, dep_a};

   for (genvar i = 0; i < NUM_STREETS; i++) begin : g_street
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             ovf_q, ovf_d;
      logic             unf_q, unf_d;

      sensor_debounce #(.DEBOUNCE(DEBOUNCE)) u_arr (
         .clk   (clk),
         .reset (reset),
         .raw   (arr_raw[i]),
         .ev    (arr_ev[i])
      );

      sensor_debounce #(.DEBOUNCE(DEBOUNCE)) u_dep (
         .clk   (clk),
         .reset (reset),
         .raw   (dep_raw[i]),
         .ev    (dep_ev[i])
      );

      // Saturating count; the flags only record misuse and never block counting.
      always_comb begin
         cnt_d = cnt_q;
         ovf_d = ovf_q;
         unf_d = unf_q;
         unique case (cnt_op(arr_ev[i], dep_ev[i]))
            CntInc: begin
               if (cnt_q == CntMax) ovf_d = 1'b1;
               else                 cnt_d = cnt_q + 1'b1;
            end
            CntDec: begin
               if (cnt_q == '0) unf_d = 1'b1;
               else             cnt_d = cnt_q - 1'b1;
            end
            default: ;
         endcase
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
         end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
         end
      end

      assign cnt_all[i] = cnt_q;
      assign ovf_all[i] = ovf_q;
      assign unf_all[i] = unf_q;
   end

   assign cnt_a = cnt_all[0];
   assign cnt_b = cnt_all[1];
   assign ovf_a = ovf_all[0];
   assign ovf_b = ovf_all[1];
   assign unf_a = unf_all[0];
   assign unf_b = unf_all[1];
   assign Ta    = (cnt_all[0] != '0);
   assign Tb    = (cnt_all[1] != '0);

endmodule

// File: tb/tb_tlc_sensor_cond.sv
// Directed bench for tlc_sensor_cond at default parameters (DEBOUNCE=3, CNT_W=4).
module tb_tlc_sensor_cond;

   logic       clk;
   logic       reset;
   logic       arr_a, dep_a, arr_b, dep_b;
   logic       Ta, Tb;
   logic [3:0] cnt_a, cnt_b;
   logic       ovf_a, ovf_b, unf_a, unf_b;

   int checks;
   int errors;

   tlc_sensor_cond dut (
      .clk   (clk),
      .reset (reset),
      .arr_a (arr_a),
      .dep_a (dep_a),
      .arr_b (arr_b),
      .dep_b (dep_b),
      .Ta    (Ta),
      .Tb    (Tb),
      .cnt_a (cnt_a),
      .cnt_b (cnt_b),
      .ovf_a (ovf_a),
      .ovf_b (ovf_b),
      .unf_a (unf_a),
      .unf_b (unf_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Raise one raw line long enough to qualify, then drop it long enough to re-arm.
   task automatic pulse(input int line);
      @(negedge clk);
      case (line)
         0: arr_a = 1'b1;
         1: dep_a = 1'b1;
         2: arr_b = 1'b1;
         default: dep_b = 1'b1;
      endcase
      repeat (6) @(negedge clk);
      arr_a = 1'b0;
      dep_a = 1'b0;
      arr_b = 1'b0;
      dep_b = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic test_reset;
      reset = 1'b1;
      arr_a = 1'b1; dep_a = 1'b1; arr_b = 1'b1; dep_b = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      arr_a = 1'b0; dep_a = 1'b0; arr_b = 1'b0; dep_b = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({Ta, Tb} !== 2'b00) begin
         errors++; $display("FAIL reset_t: got %b expected 00", {Ta, Tb});
      end
      checks++;
      if ({cnt_a, cnt_b} !== 8'h00) begin
         errors++; $display("FAIL reset_cnt: got %h expected 00", {cnt_a, cnt_b});
      end
      checks++;
      if ({ovf_a, ovf_b, unf_a, unf_b} !== 4'b0000) begin
         errors++; $display("FAIL reset_flags: got %b expected 0000", {ovf_a, ovf_b, unf_a, unf_b});
      end
   endtask

   task automatic test_clean_arrival;
      @(negedge clk);
      arr_a = 1'b1;
      repeat (5) @(posedge clk); #1;
      checks++;
      if (cnt_a !== 4'd0) begin
         errors++; $display("FAIL arr_edge5_cnt: got %0d expected 0", cnt_a);
      end
      @(posedge clk); #1;
      checks++;
      if (cnt_a !== 4'd1 || Ta !== 1'b1) begin
         errors++; $display("FAIL arr_edge6: got cnt=%0d Ta=%b expected cnt=1 Ta=1", cnt_a, Ta);
      end
      repeat (2) @(posedge clk); #1;
      @(negedge clk);
      arr_a = 1'b0;
      repeat (6) @(negedge clk);
      checks++;
      if (cnt_a !== 4'd1) begin
         errors++; $display("FAIL arr_hold_cnt: got %0d expected 1", cnt_a);
      end
      checks++;
      if ({Tb, cnt_b, ovf_a, ovf_b, unf_a, unf_b} !== 9'b0) begin
         errors++;
         $display("FAIL arr_side: got Tb=%b cnt_b=%0d flags=%b expected all 0",
                  Tb, cnt_b, {ovf_a, ovf_b, unf_a, unf_b});
      end
   endtask

   task automatic test_glitch;
      @(negedge clk);
      arr_b = 1'b1;
      repeat (2) @(negedge clk);
      arr_b = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         checks++;
         if (Tb !== 1'b0 || cnt_b !== 4'd0) begin
            errors++; $display("FAIL glitch_c%0d: got Tb=%b cnt_b=%0d expected 0 0", i, Tb, cnt_b);
         end
      end
   endtask

   task automatic test_arr_dep;
      @(negedge clk);
      arr_a = 1'b1;
      dep_a = 1'b1;
      repeat (8) @(posedge clk); #1;
      checks++;
      if (cnt_a !== 4'd1 || Ta !== 1'b1) begin
         errors++; $display("FAIL arrdep_same: got cnt=%0d Ta=%b expected cnt=1 Ta=1", cnt_a, Ta);
      end
      @(negedge clk);
      arr_a = 1'b0;
      dep_a = 1'b0;
      repeat (6) @(negedge clk);
      dep_a = 1'b1;
      repeat (5) @(posedge clk); #1;
      checks++;
      if (cnt_a !== 4'd1) begin
         errors++; $display("FAIL dep_edge5: got %0d expected 1", cnt_a);
      end
      @(posedge clk); #1;
      checks++;
      if (cnt_a !== 4'd0 || Ta !== 1'b0 || unf_a !== 1'b0) begin
         errors++;
         $display("FAIL dep_edge6: got cnt=%0d Ta=%b unf=%b expected 0 0 0", cnt_a, Ta, unf_a);
      end
      @(negedge clk);
      dep_a = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic test_saturation;
      for (int i = 0; i < 15; i++) pulse(0);
      checks++;
      if (cnt_a !== 4'd15 || ovf_a !== 1'b0) begin
         errors++; $display("FAIL sat_15: got cnt=%0d ovf=%b expected 15 0", cnt_a, ovf_a);
      end
      pulse(0);
      checks++;
      if (cnt_a !== 4'd15 || ovf_a !== 1'b1 || Ta !== 1'b1) begin
         errors++;
         $display("FAIL sat_16: got cnt=%0d ovf=%b Ta=%b expected 15 1 1", cnt_a, ovf_a, Ta);
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if (cnt_a !== 4'd0 || ovf_a !== 1'b0 || Ta !== 1'b0) begin
         errors++; $display("FAIL sat_reset: got cnt=%0d ovf=%b Ta=%b expected 0 0 0", cnt_a, ovf_a, Ta);
      end
      pulse(3);
      checks++;
      if (cnt_b !== 4'd0 || unf_b !== 1'b1 || Tb !== 1'b0 || unf_a !== 1'b0) begin
         errors++;
         $display("FAIL unf_b: got cnt_b=%0d unf_b=%b Tb=%b unf_a=%b expected 0 1 0 0",
                  cnt_b, unf_b, Tb, unf_a);
      end
   endtask

   task automatic test_mid_reset;
      @(negedge clk);
      arr_a = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({Ta, Tb, cnt_a, cnt_b, ovf_a, ovf_b, unf_a, unf_b} !== 14'b0) begin
         errors++;
         $display("FAIL midrst_state: got Ta=%b Tb=%b cnt_a=%0d cnt_b=%0d flags=%b expected all 0",
                  Ta, Tb, cnt_a, cnt_b, {ovf_a, ovf_b, unf_a, unf_b});
      end
      @(negedge clk);
      reset = 1'b0;
      repeat (5) @(posedge clk); #1;
      checks++;
      if (cnt_a !== 4'd0) begin
         errors++; $display("FAIL midrst_edge5: got %0d expected 0", cnt_a);
      end
      @(posedge clk); #1;
      checks++;
      if (cnt_a !== 4'd1 || Ta !== 1'b1) begin
         errors++; $display("FAIL midrst_edge6: got cnt=%0d Ta=%b expected 1 1", cnt_a, Ta);
      end
      @(negedge clk);
      arr_a = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_clean_arrival();
      test_glitch();
      test_arr_dep();
      test_saturation();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
